// File: rtl/tw_seq_gen_if.sv
// Command and twiddle-stream bundle for tw_seq_gen.
// The master issues commands and consumes beats; the slave is the sequencer.
interface tw_seq_gen_if #(
    parameter int unsigned TW_W = 18,
    parameter int unsigned AW   = 8,
    parameter int unsigned LW   = 12
);
    logic                   start;
    logic [AW-1:0]          stride;
    logic [AW-1:0]          base;
    logic [LW-1:0]          len;
    logic                   inverse;
    logic                   busy;
    logic                   tw_valid;
    logic                   tw_ready;
    logic signed [TW_W-1:0] tw_re;
    logic signed [TW_W-1:0] tw_im;
    logic [AW-1:0]          tw_idx;
    logic                   tw_last;
    logic                   done;

    modport master (
        output start, stride, base, len, inverse, tw_ready,
        input  busy, tw_valid, tw_re, tw_im, tw_idx, tw_last, done
    );

    modport slave (
        input  start, stride, base, len, inverse, tw_ready,
        output busy, tw_valid, tw_re, tw_im, tw_idx, tw_last, done
    );
endinterface

// File: rtl/tw_seq_gen.sv
// Streaming twiddle-factor sequencer: phase accumulator over N_MAX points,
// quarter-wave cosine ROM, three-stage pipeline with valid/ready backpressure.
module tw_seq_gen #(
    parameter int unsigned TW_W  = 18,
    parameter int unsigned FRAC  = 10,
    parameter int unsigned N_MAX = 144,
    parameter int unsigned AW    = $clog2(N_MAX),
    parameter int unsigned LW    = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    tw_seq_gen_if.slave  bus
);
    localparam int unsigned Q  = N_MAX / 4;
    localparam int unsigned RW = $clog2(Q + 1);
    localparam int unsigned SW = AW + 1;
    localparam real         PI = 3.14159265358979323846;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    // Quarter-wave table entry; endpoints are pinned so +1.0 and 0 are exact.
    function automatic logic signed [TW_W-1:0] cos_q(input int unsigned r);
        real v;
        if (r == 0) return TW_W'(1 << FRAC);
        if (r == Q) return '0;
        v = real'(1 << FRAC) * $cos(2.0 * PI * real'(r) / real'(N_MAX));
        return TW_W'($rtoi(v + 0.5));
    endfunction

    logic signed [TW_W-1:0] rom [Q+1];

    for (genvar g = 0; g <= int'(Q); g++) begin : g_rom
        localparam logic signed [TW_W-1:0] CV = cos_q(g);
        assign rom[g] = CV;
    end

    logic [1:0]             state, state_nxt;
    logic                   busy_q, busy_nxt;
    logic                   done_q, done_nxt;
    logic                   accept, issue, advance;

    logic [AW-1:0]          acc, acc_nxt, stride_q;
    logic [LW-1:0]          rem;
    logic                   inv_q;
    logic [SW-1:0]          sum;

    logic                   p1_vld, p1_inv, p1_last;
    logic [1:0]             p1_q;
    logic [RW-1:0]          p1_r;
    logic [AW-1:0]          p1_idx;

    logic                   out_vld, out_last;
    logic signed [TW_W-1:0] out_re, out_im;
    logic [AW-1:0]          out_idx;

    logic signed [TW_W-1:0] ra, rb, c_v, s_v, im_v;

    // Whole pipeline and accumulator freeze while a presented beat is refused.
    assign advance = !(out_vld && !bus.tw_ready);

    // Modular phase step without a power-of-two wrap.
    always_comb begin
        sum     = {1'b0, acc} + {1'b0, stride_q};
        acc_nxt = (sum >= SW'(N_MAX)) ? AW'(sum - SW'(N_MAX)) : AW'(sum);
    end

    // Control FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
        end
    end

    // Next state, command accept and issue control.
    always_comb begin
        state_nxt = state;
        busy_nxt  = busy_q;
        done_nxt  = 1'b0;
        accept    = 1'b0;
        issue     = 1'b0;
        if (done_q) busy_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start && !busy_q) begin
                    accept = 1'b1;
                    if (bus.len != '0) begin
                        state_nxt = S_RUN;
                        busy_nxt  = 1'b1;
                    end else begin
                        done_nxt  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (advance) begin
                    issue = 1'b1;
                    if (rem == LW'(1)) state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_vld && bus.tw_ready && out_last) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // P0: command capture and accumulator issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            stride_q <= '0;
            rem      <= '0;
            inv_q    <= 1'b0;
        end else if (accept) begin
            acc      <= bus.base;
            stride_q <= bus.stride;
            rem      <= bus.len;
            inv_q    <= bus.inverse;
        end else if (issue) begin
            acc      <= acc_nxt;
            rem      <= rem - LW'(1);
        end
    end

    // P1: quadrant split of the issued index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_vld  <= 1'b0;
            p1_q    <= '0;
            p1_r    <= '0;
            p1_inv  <= 1'b0;
            p1_last <= 1'b0;
            p1_idx  <= '0;
        end else if (advance) begin
            p1_vld <= issue;
            if (issue) begin
                p1_q    <= 2'(acc / AW'(Q));
                p1_r    <= RW'(acc % AW'(Q));
                p1_inv  <= inv_q;
                p1_last <= (rem == LW'(1));
                p1_idx  <= acc;
            end
        end
    end

    // P2 combinational: two ROM reads, then quadrant sign/swap.
    always_comb begin
        ra = rom[p1_r];
        rb = rom[RW'(Q) - p1_r];
        c_v = ra;
        s_v = rb;
        case (p1_q)
            2'd0: begin c_v =  ra; s_v =  rb; end
            2'd1: begin c_v = -rb; s_v =  ra; end
            2'd2: begin c_v = -ra; s_v = -rb; end
            default: begin c_v = rb; s_v = -ra; end
        endcase
        im_v = p1_inv ? s_v : -s_v;
    end

    // P2 output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_last <= 1'b0;
            out_re   <= '0;
            out_im   <= '0;
            out_idx  <= '0;
        end else if (advance) begin
            out_vld  <= p1_vld;
            out_last <= p1_vld && p1_last;
            if (p1_vld) begin
                out_re  <= c_v;
                out_im  <= im_v;
                out_idx <= p1_idx;
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.tw_valid = out_vld;
    assign bus.tw_last  = out_last;
    assign bus.tw_re    = out_re;
    assign bus.tw_im    = out_im;
    assign bus.tw_idx   = out_idx;
endmodule
